// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the serial instruction loader: FSM encoding, command bytes
// and the halt word that terminates a program image.
package instruction_loader_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StReady = 2'd2,
        StRun   = 2'd3
    } state_e;

    localparam logic [7:0]  CMD_LOAD  = 8'h4C;
    localparam logic [7:0]  CMD_RUN   = 8'h52;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Packs received bytes MSB-first into instruction words; word_done flags the byte that
// completes a word, with the finished word presented alongside it.
module word_assembler #(
    parameter int unsigned NBITS = 32,
    parameter int unsigned BBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             byte_valid,
    input  logic [BBITS-1:0] byte_data,
    output logic [NBITS-1:0] word,
    output logic             word_done
);

    localparam logic [1:0] LastByte = 2'(NBITS / BBITS - 1);

    logic [NBITS-1:0] shift_q;
    logic [1:0]       cnt_q;

    // The completed word includes the byte arriving this cycle, so the top can register it
    // on the same edge and raise the write strobe one cycle after the final byte.
    assign word      = {shift_q[NBITS-BBITS-1:0], byte_data};
    assign word_done = byte_valid && (cnt_q == LastByte);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (byte_valid) begin
            shift_q <= word;
            cnt_q   <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Loads a program image from a byte stream into instruction memory, then gates the
// pipeline between load, ready and run phases under host command bytes.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned NBITS    = 32,
    parameter int unsigned MEM_SIZE = 1024,
    parameter int unsigned BBITS    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [BBITS-1:0] i_rx_data,
    input  logic             i_rx_valid,
    input  logic             i_cpu_halt,
    output logic             o_imem_we,
    output logic [NBITS-1:0] o_imem_addr,
    output logic [NBITS-1:0] o_imem_data,
    output logic             o_cpu_en,
    output logic             o_loaded,
    output logic             o_error,
    output logic [NBITS-1:0] o_word_count
);

    localparam logic [NBITS-1:0] LastAddr = NBITS'(MEM_SIZE - 1);
    localparam logic [NBITS-1:0] HaltWord = NBITS'(HALT_WORD);

    state_e           state_q, state_d;
    logic             start_load;
    logic             word_done;
    logic [NBITS-1:0] word;
    logic [NBITS-1:0] addr_q;
    logic             we_q, cpu_en_q, loaded_q, error_q;
    logic [NBITS-1:0] wr_addr_q, wr_data_q, word_count_q;
    logic             halt_pend_q, ovf_pend_q;

    word_assembler #(
        .NBITS (NBITS),
        .BBITS (BBITS)
    ) u_word_assembler (
        .clk        (i_clk),
        .rst        (i_rst),
        .clear      (start_load),
        .byte_valid (i_rx_valid && (state_q == StLoad)),
        .byte_data  (i_rx_data),
        .word       (word),
        .word_done  (word_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_rx_valid && (i_rx_data == BBITS'(CMD_LOAD))) begin
                    state_d    = StLoad;
                    start_load = 1'b1;
                end
            end
            StLoad: begin
                // Leave only once the final write strobe is on the bus, keeping it inside LOAD.
                if (we_q && halt_pend_q) begin
                    state_d = StReady;
                end else if (we_q && ovf_pend_q) begin
                    state_d = StIdle;
                end
            end
            StReady: begin
                if (i_rx_valid && (i_rx_data == BBITS'(CMD_RUN))) begin
                    state_d = StRun;
                end else if (i_rx_valid && (i_rx_data == BBITS'(CMD_LOAD))) begin
                    state_d    = StLoad;
                    start_load = 1'b1;
                end
            end
            StRun: begin
                if (i_cpu_halt) begin
                    state_d = StReady;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q       <= '0;
            we_q         <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            word_count_q <= '0;
            cpu_en_q     <= 1'b0;
            loaded_q     <= 1'b0;
            error_q      <= 1'b0;
            halt_pend_q  <= 1'b0;
            ovf_pend_q   <= 1'b0;
        end else begin
            we_q     <= 1'b0;
            cpu_en_q <= (state_d == StRun);
            if (start_load) begin
                addr_q       <= '0;
                word_count_q <= '0;
                loaded_q     <= 1'b0;
                error_q      <= 1'b0;
                halt_pend_q  <= 1'b0;
                ovf_pend_q   <= 1'b0;
            end
            if (word_done) begin
                we_q         <= 1'b1;
                wr_addr_q    <= addr_q;
                wr_data_q    <= word;
                addr_q       <= addr_q + NBITS'(1);
                word_count_q <= word_count_q + NBITS'(1);
                halt_pend_q  <= (word == HaltWord);
                ovf_pend_q   <= (word != HaltWord) && (addr_q == LastAddr);
            end
            if ((state_q == StLoad) && (state_d == StReady)) begin
                loaded_q <= 1'b1;
            end
            if ((state_q == StLoad) && (state_d == StIdle)) begin
                error_q <= 1'b1;
            end
        end
    end

    assign o_imem_we    = we_q;
    assign o_imem_addr  = wr_addr_q;
    assign o_imem_data  = wr_data_q;
    assign o_cpu_en     = cpu_en_q;
    assign o_loaded     = loaded_q;
    assign o_error      = error_q;
    assign o_word_count = word_count_q;

endmodule
